// File: rtl/riscv_types.sv
// Shared types for the execute-stage ALU: operation codes, FSM states and
// small op-class helpers used by the iterative multiply/divide unit.
package riscv_types;

    // Base ops first, then the RV32M multiply/divide family.
    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLT    = 5'd2,
        OP_SLTU   = 5'd3,
        OP_SLL    = 5'd4,
        OP_SRL    = 5'd5,
        OP_SRA    = 5'd6,
        OP_XOR    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_MUL    = 5'd10,
        OP_MULH   = 5'd11,
        OP_MULHSU = 5'd12,
        OP_MULHU  = 5'd13,
        OP_DIV    = 5'd14,
        OP_DIVU   = 5'd15,
        OP_REM    = 5'd16,
        OP_REMU   = 5'd17
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    function automatic logic is_mul(alu_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic is_div(alu_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/base_alu_comb.sv
// Single-cycle base ALU: add/sub, compares, shifts and logic ops.
// Any code it does not recognise behaves as ADD.
module base_alu_comb
    import riscv_types::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_t           op,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [XLEN-1:0]   y
);

    localparam int SHAMT_W = $clog2(XLEN);

    logic [SHAMT_W-1:0] shamt;

    assign shamt = b[SHAMT_W-1:0];

    // Select the base-op result; compares are zero-extended to XLEN.
    always_comb begin
        y = a + b;
        case (op)
            OP_SUB:  y = a - b;
            OP_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
            OP_SLL:  y = a << shamt;
            OP_SRL:  y = a >> shamt;
            OP_SRA:  y = $unsigned($signed(a) >>> shamt);
            OP_XOR:  y = a ^ b;
            OP_OR:   y = a | b;
            OP_AND:  y = a & b;
            default: y = a + b;
        endcase
    end

endmodule

// File: rtl/iter_muldiv_alu.sv
// Execute-stage unit: base ALU ops in one cycle, RV32M multiply/divide on a
// one-bit-per-cycle shift-add / restoring-divide datapath behind valid/ready.
module iter_muldiv_alu
    import riscv_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  alu_op_t           op,
    input  logic [XLEN-1:0]   op1,
    input  logic [XLEN-1:0]   op2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic              zero
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    muldiv_state_t     state, state_nxt;
    alu_op_t           op_q;
    logic [CNT_W-1:0]  cnt;

    logic [2*XLEN-1:0] acc, mcand, acc_nxt, prod;
    logic [XLEN-1:0]   mplier;

    logic [XLEN-1:0]   rem, dvd, dvsr, rem_nxt, dvd_nxt;
    logic [XLEN:0]     rem_sh, trial;
    logic              neg_q, neg_r;

    logic [XLEN-1:0]   base_y, fast_y, mul_y, div_y, q_fin, r_fin;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              sign_a, sign_b, div_zero, div_ovf, div_fast, accept;

    base_alu_comb #(.XLEN(XLEN)) u_base_alu (
        .op (op),
        .a  (op1),
        .b  (op2),
        .y  (base_y)
    );

    assign accept = in_valid && in_ready && !flush;

    // Operand decode at accept: sign extraction, magnitudes and divide fast paths.
    always_comb begin
        sign_a   = op1[XLEN-1] && (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        sign_b   = op2[XLEN-1] && (op inside {OP_MULH, OP_DIV, OP_REM});
        mag_a    = sign_a ? (~op1 + 1'b1) : op1;
        mag_b    = sign_b ? (~op2 + 1'b1) : op2;
        div_zero = (op2 == '0);
        div_ovf  = (op inside {OP_DIV, OP_REM}) &&
                   (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
        div_fast = div_zero || div_ovf;
        fast_y   = '0;
        if (div_zero) begin
            fast_y = (op inside {OP_DIV, OP_DIVU}) ? '1 : op1;
        end else if (div_ovf) begin
            fast_y = (op == OP_DIV) ? op1 : '0;
        end
    end

    // One iteration of both datapaths plus the sign-corrected final values,
    // which are latched on the last iteration so the result lands with DONE.
    always_comb begin
        acc_nxt = mplier[0] ? (acc + mcand) : acc;
        prod    = neg_q ? (~acc_nxt + 1'b1) : acc_nxt;
        mul_y   = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

        rem_sh  = {rem, dvd[XLEN-1]};
        trial   = rem_sh - {1'b0, dvsr};
        rem_nxt = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
        dvd_nxt = {dvd[XLEN-2:0], ~trial[XLEN]};
        q_fin   = neg_q ? (~dvd_nxt + 1'b1) : dvd_nxt;
        r_fin   = neg_r ? (~rem_nxt + 1'b1) : rem_nxt;
        div_y   = (op_q inside {OP_DIV, OP_DIVU}) ? q_fin : r_fin;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush returns to IDLE from anywhere.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (is_mul(op)) begin
                            state_nxt = MUL;
                        end else if (is_div(op) && !div_fast) begin
                            state_nxt = DIV;
                        end else begin
                            state_nxt = DONE;
                        end
                    end
                end
                MUL:     if (cnt == CNT_W'(1)) state_nxt = DONE;
                DIV:     if (cnt == CNT_W'(1)) state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from the state; zero tracks the held result.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        zero      = (result == '0);
    end

    // Datapath registers: operand capture, per-bit iteration and result latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= OP_ADD;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            rem    <= '0;
            dvd    <= '0;
            dvsr   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
        end else if (!flush) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q <= op;
                        if (is_mul(op)) begin
                            cnt    <= CNT_W'(XLEN);
                            acc    <= '0;
                            mcand  <= {{XLEN{1'b0}}, mag_a};
                            mplier <= mag_b;
                            neg_q  <= sign_a ^ sign_b;
                        end else if (is_div(op)) begin
                            if (div_fast) begin
                                result <= fast_y;
                            end else begin
                                cnt   <= CNT_W'(XLEN);
                                rem   <= '0;
                                dvd   <= mag_a;
                                dvsr  <= mag_b;
                                neg_q <= sign_a ^ sign_b;
                                neg_r <= sign_a;
                            end
                        end else begin
                            result <= base_y;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) result <= mul_y;
                end
                DIV: begin
                    rem <= rem_nxt;
                    dvd <= dvd_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) result <= div_y;
                end
                default: ;
            endcase
        end
    end

endmodule
